unidade_controle_multiciclo: RTL and testbench
==============================================

Name: unidade_controle_multiciclo

Overview:
Parametrised multicycle successor to the single-cycle control unit of the 8-bit processor. It is a Moore FSM that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the same datapath control set plus IRWrite.
- Stretches memory phases on a ready handshake.
- Flags illegal opcodes, supports HALT, and counts retired instructions.

Parameters:
OPCODE_W, 2, opcode width; opcodes above 3 are illegal
FUNCT_W, 3, funct width (min 2)
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
Opcode  in  OPCODE_W  opcode field from the instruction register
Funct  in  FUNCT_W  funct field from the instruction register
Zero  in  1  ALU zero flag, sampled in EXEC
MemReady  in  1  memory access done this cycle
PCWrite, IRWrite, RegOrg1, RegOrg2, RegDst, RegWrite, ALUSrc1, Cond, Jump, MenWrite, MenRead, MenToReg  out  1 each  datapath controls
ALUSrc2, ALUOp, JumpValue  out  2 each  datapath controls
Illegal  out  1  one-cycle pulse on an illegal opcode
Halted  out  1  high while in HALT
InstrCount  out  CNT_W  retired instructions, wraps

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; InstrCount=0.
  - Every output is 0 while in reset and in IDLE.
- IDLE: one cycle after reset release, then FETCH.
- Outputs are a combinational decode of the state register and the latched class/funct. Any output not listed for a state is 0.
- Class is latched in DECODE from Opcode: 0=R, 1=I, 2=MEM, 3=JMP; anything else is ILL. Funct is latched in the same cycle.
- FETCH:
  - Asserts MenRead=1, ALUSrc1=0, ALUSrc2=01 (constant 1), ALUOp=00.
  - While MemReady=0: hold in FETCH, IRWrite=0, PCWrite=0.
  - Cycle with MemReady=1: IRWrite=1 and PCWrite=1, then go to DECODE.
- DECODE:
  - Asserts RegOrg1=1, RegOrg2=1; latches the fields.
  - ILL: Illegal=1 this cycle, go to FETCH, no retire.
  - JMP with Funct all ones: go to HALT.
  - Otherwise go to EXEC.
- EXEC by class:
  - R: ALUSrc1=1, ALUSrc2=00, ALUOp=10; go to WB.
  - I: ALUSrc1=1, ALUSrc2=10, ALUOp=11; go to WB.
  - MEM: ALUSrc1=1, ALUSrc2=10, ALUOp=00 (address); go to MEM.
  - JMP: Jump=1, Cond=Funct[0], JumpValue=Funct[2:1], PCWrite=(~Funct[0]) | Zero. Retire and go to FETCH.
- MEM:
  - Funct[0]=0 is a load: MenRead=1.
  - Funct[0]=1 is a store: MenWrite=1.
  - Hold in MEM while MemReady=0.
  - On MemReady=1: a load goes to WB; a store retires and goes to FETCH.
- WB:
  - RegWrite=1, RegDst=(class==R), MenToReg=(class==MEM).
  - Retire and go to FETCH.
- HALT:
  - Halted=1; all other outputs 0.
  - Stays in HALT until reset; no retire.
- Retire: InstrCount += 1 on the clock edge that leaves the final state. It wraps from 2^CNT_W-1 to 0.
- Multicycle latencies with MemReady tied 1: R/I 4 cycles, load 5, store 4, jump 3.
- MemReady outside FETCH/MEM is ignored.
- Reset mid-instruction: aborts immediately and restarts from IDLE; no partial retire.
- X on Opcode outside DECODE has no effect.

Decomposition:
- Shared package uc_pkg holds:
  - state enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT);
  - class codes (R, I, MEM, JMP, ILL);
  - ALUOp constants (ADD=00, FUNCT=10, IMM=11);
  - ALUSrc2 constants (REG=00, ONE=01, IMM=10).
- One natural sub-module, uc_decode_saidas: the purely combinational map from state/class/funct to all control outputs.
- The top level holds the state register, field latches and counter.

Test Plan:
- Reset, then release with MemReady=1 and Opcode=00, Funct=010. Required:
  - IDLE shows all outputs 0 for 1 cycle.
  - FETCH shows MenRead=1, IRWrite=1, PCWrite=1.
  - DECODE, then EXEC shows ALUOp=10.
  - WB shows RegWrite=1, RegDst=1.
  - InstrCount=1.
- Load (Opcode=10, Funct=000) with MemReady low for 3 MEM cycles -> MEM held 4 cycles with MenRead=1, then WB with MenToReg=1; latency 8 cycles.
- Store (Opcode=10, Funct=001) -> MenWrite=1 in MEM; RegWrite never 1; next state FETCH.
- Conditional jump, Opcode=11, Funct=001:
  - Zero=0 -> EXEC with Jump=1, Cond=1, PCWrite=0.
  - Zero=1 -> PCWrite=1.
  - Funct=110 -> PCWrite=1 regardless of Zero, JumpValue=11.
- OPCODE_W=3, Opcode=101 -> Illegal pulses 1 cycle in DECODE, returns to FETCH, InstrCount unchanged.
- Both of the following, as separate runs:
  - CNT_W=2 with 4 retires -> InstrCount wraps 3 to 0.
  - Opcode=11, Funct=111 -> Halted=1, held 20 cycles; then rst_n pulse low asynchronously mid-cycle -> immediate IDLE, all outputs 0.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared types and datapath control encodings for the multicycle control unit.
package uc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_MEM = 3'd2,
        CLS_JMP = 3'd3,
        CLS_ILL = 3'd4
    } class_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] SRC2_REG = 2'b00;
    localparam logic [1:0] SRC2_ONE = 2'b01;
    localparam logic [1:0] SRC2_IMM = 2'b10;

    // Opcode is passed zero-extended so the map works for any OPCODE_W.
    function automatic class_t classify(input logic [31:0] opcode);
        class_t cls;
        if (opcode > 32'd3) begin
            cls = CLS_ILL;
        end else begin
            cls = class_t'({1'b0, opcode[1:0]});
        end
        return cls;
    endfunction

endpackage

// File: rtl/uc_decode_saidas.sv
// Combinational map from state, latched class/funct and live flags to datapath controls.
module uc_decode_saidas
    import uc_pkg::*;
(
    input  state_t     state,
    input  class_t     cls,
    input  logic [2:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       opcode_illegal,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_org1,
    output logic       reg_org2,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src1,
    output logic       cond,
    output logic       jump,
    output logic       men_write,
    output logic       men_read,
    output logic       men_to_reg,
    output logic [1:0] alu_src2,
    output logic [1:0] alu_op,
    output logic [1:0] jump_value,
    output logic       illegal,
    output logic       halted
);

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_org1   = 1'b0;
        reg_org2   = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src1   = 1'b0;
        cond       = 1'b0;
        jump       = 1'b0;
        men_write  = 1'b0;
        men_read   = 1'b0;
        men_to_reg = 1'b0;
        alu_src2   = SRC2_REG;
        alu_op     = ALUOP_ADD;
        jump_value = 2'b00;
        illegal    = 1'b0;
        halted     = 1'b0;
        case (state)
            ST_FETCH: begin
                men_read = 1'b1;
                alu_src2 = SRC2_ONE;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            ST_DECODE: begin
                reg_org1 = 1'b1;
                reg_org2 = 1'b1;
                illegal  = opcode_illegal;
            end
            ST_EXEC: begin
                case (cls)
                    CLS_R: begin
                        alu_src1 = 1'b1;
                        alu_src2 = SRC2_REG;
                        alu_op   = ALUOP_FUNCT;
                    end
                    CLS_I: begin
                        alu_src1 = 1'b1;
                        alu_src2 = SRC2_IMM;
                        alu_op   = ALUOP_IMM;
                    end
                    CLS_MEM: begin
                        alu_src1 = 1'b1;
                        alu_src2 = SRC2_IMM;
                        alu_op   = ALUOP_ADD;
                    end
                    CLS_JMP: begin
                        jump       = 1'b1;
                        cond       = funct[0];
                        jump_value = funct[2:1];
                        pc_write   = ~funct[0] | zero;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                men_read  = ~funct[0];
                men_write = funct[0];
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (cls == CLS_R);
                men_to_reg = (cls == CLS_MEM);
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle Moore control unit: state register, decode-time field latches and retire counter.
module unidade_controle_multiciclo
    import uc_pkg::*;
#(
    parameter int unsigned OPCODE_W = 2,
    parameter int unsigned FUNCT_W  = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic [FUNCT_W-1:0]  Funct,
    input  logic                Zero,
    input  logic                MemReady,
    output logic                PCWrite,
    output logic                IRWrite,
    output logic                RegOrg1,
    output logic                RegOrg2,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrc1,
    output logic                Cond,
    output logic                Jump,
    output logic                MenWrite,
    output logic                MenRead,
    output logic                MenToReg,
    output logic [1:0]          ALUSrc2,
    output logic [1:0]          ALUOp,
    output logic [1:0]          JumpValue,
    output logic                Illegal,
    output logic                Halted,
    output logic [CNT_W-1:0]    InstrCount
);

    state_t             state_q, state_d;
    class_t             cls_q, cls_d;
    logic [FUNCT_W-1:0] funct_q, funct_d;
    logic [CNT_W-1:0]   count_q, count_d;
    class_t             opcode_cls;
    logic [2:0]         funct3;
    logic               retire;

    assign opcode_cls = classify(32'(Opcode));

    // Narrow funct fields are zero-extended so the jump-target select stays defined.
    if (FUNCT_W >= 3) begin : g_funct_wide
        assign funct3 = funct_q[2:0];
    end else begin : g_funct_narrow
        assign funct3 = {1'b0, funct_q[1:0]};
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        funct_d = funct_q;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (MemReady) state_d = ST_DECODE;
            ST_DECODE: begin
                cls_d   = opcode_cls;
                funct_d = Funct;
                if (opcode_cls == CLS_ILL) begin
                    state_d = ST_FETCH;
                end else if (opcode_cls == CLS_JMP && (&Funct)) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_R, CLS_I: state_d = ST_WB;
                    CLS_MEM:      state_d = ST_MEM;
                    default: begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                if (MemReady) begin
                    if (funct3[0]) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
        count_d = retire ? count_q + CNT_W'(1) : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cls_q   <= CLS_R;
            funct_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            funct_q <= funct_d;
            count_q <= count_d;
        end
    end

    assign InstrCount = count_q;

    uc_decode_saidas u_decode_saidas (
        .state          (state_q),
        .cls            (cls_q),
        .funct          (funct3),
        .zero           (Zero),
        .mem_ready      (MemReady),
        .opcode_illegal (opcode_cls == CLS_ILL),
        .pc_write       (PCWrite),
        .ir_write       (IRWrite),
        .reg_org1       (RegOrg1),
        .reg_org2       (RegOrg2),
        .reg_dst        (RegDst),
        .reg_write      (RegWrite),
        .alu_src1       (ALUSrc1),
        .cond           (Cond),
        .jump           (Jump),
        .men_write      (MenWrite),
        .men_read       (MenRead),
        .men_to_reg     (MenToReg),
        .alu_src2       (ALUSrc2),
        .alu_op         (ALUOp),
        .jump_value     (JumpValue),
        .illegal        (Illegal),
        .halted         (Halted)
    );

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench: a default instance plus a 3-bit-opcode, 2-bit-counter instance sharing stimulus.
module tb_unidade_controle_multiciclo;

    typedef struct packed {
        logic       pcw, irw, ro1, ro2, rdst, rw, as1, cond, jump, mw, mr, m2r;
        logic [1:0] as2, aluop, jv;
        logic       ill, halted;
    } ctl_t;

    typedef struct {
        logic [1:0] opc;
        logic [2:0] f;
        logic       z;
        int         mwait;
        int         cyc;
        int         rw;
        int         mw;
        int         m2r;
        int         pcw;
        int         ret;
    } vec_t;

    logic       clk, rst_n;
    logic [1:0] opcode;
    logic       opc_hi;
    logic [2:0] funct;
    logic       zero, mem_ready;

    logic a_pcw, a_irw, a_ro1, a_ro2, a_rdst, a_rw, a_as1, a_cond, a_jump, a_mw, a_mr, a_m2r, a_ill, a_halted;
    logic [1:0] a_as2, a_aluop, a_jv;
    logic [15:0] a_cnt;
    logic b_pcw, b_irw, b_ro1, b_ro2, b_rdst, b_rw, b_as1, b_cond, b_jump, b_mw, b_mr, b_m2r, b_ill, b_halted;
    logic [1:0] b_as2, b_aluop, b_jv;
    logic [1:0] b_cnt;
    ctl_t ctl_a, ctl_b;

    int checks = 0;
    int failures = 0;
    int exp_count = 0;

    assign ctl_a = {a_pcw, a_irw, a_ro1, a_ro2, a_rdst, a_rw, a_as1, a_cond, a_jump, a_mw, a_mr, a_m2r,
                    a_as2, a_aluop, a_jv, a_ill, a_halted};
    assign ctl_b = {b_pcw, b_irw, b_ro1, b_ro2, b_rdst, b_rw, b_as1, b_cond, b_jump, b_mw, b_mr, b_m2r,
                    b_as2, b_aluop, b_jv, b_ill, b_halted};

    unidade_controle_multiciclo dut_a (
        .clk(clk), .rst_n(rst_n), .Opcode(opcode), .Funct(funct), .Zero(zero), .MemReady(mem_ready),
        .PCWrite(a_pcw), .IRWrite(a_irw), .RegOrg1(a_ro1), .RegOrg2(a_ro2), .RegDst(a_rdst),
        .RegWrite(a_rw), .ALUSrc1(a_as1), .Cond(a_cond), .Jump(a_jump), .MenWrite(a_mw),
        .MenRead(a_mr), .MenToReg(a_m2r), .ALUSrc2(a_as2), .ALUOp(a_aluop), .JumpValue(a_jv),
        .Illegal(a_ill), .Halted(a_halted), .InstrCount(a_cnt)
    );

    unidade_controle_multiciclo #(.OPCODE_W(3), .FUNCT_W(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .Opcode({opc_hi, opcode}), .Funct(funct), .Zero(zero), .MemReady(mem_ready),
        .PCWrite(b_pcw), .IRWrite(b_irw), .RegOrg1(b_ro1), .RegOrg2(b_ro2), .RegDst(b_rdst),
        .RegWrite(b_rw), .ALUSrc1(b_as1), .Cond(b_cond), .Jump(b_jump), .MenWrite(b_mw),
        .MenRead(b_mr), .MenToReg(b_m2r), .ALUSrc2(b_as2), .ALUOp(b_aluop), .JumpValue(b_jv),
        .Illegal(b_ill), .Halted(b_halted), .InstrCount(b_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_ctl(input string name, input ctl_t act, input ctl_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_count();
        check_int("count_a", int'(a_cnt), exp_count % 65536);
        check_int("count_b", int'(b_cnt), exp_count % 4);
    endtask

    task automatic junk();
        opcode = 2'($urandom);
        funct  = 3'($urandom);
        zero   = 1'($urandom);
    endtask

    function automatic ctl_t fetch_exp(input logic rdy);
        ctl_t e = '0;
        e.mr  = 1'b1;
        e.as2 = 2'b01;
        e.irw = rdy;
        e.pcw = rdy;
        return e;
    endfunction

    // Walks one instruction phase by phase from a FETCH cycle, checking every cycle.
    task automatic run_instr(input logic [1:0] opc, input logic [2:0] f, input logic z,
                             input int fwait, input int mwait);
        ctl_t e;
        check_count();
        for (int w = 0; w <= fwait; w++) begin
            junk();
            mem_ready = (w == fwait);
            #1 check_ctl("fetch", ctl_a, fetch_exp(mem_ready));
            @(negedge clk);
        end
        opcode = opc; funct = f; zero = 1'($urandom); mem_ready = 1'($urandom);
        #1 e = '0; e.ro1 = 1'b1; e.ro2 = 1'b1;
        check_ctl("decode", ctl_a, e);
        @(negedge clk);
        junk(); zero = z; mem_ready = 1'($urandom);
        #1 e = '0;
        case (opc)
            2'd0: begin e.as1 = 1'b1; e.as2 = 2'b00; e.aluop = 2'b10; end
            2'd1: begin e.as1 = 1'b1; e.as2 = 2'b10; e.aluop = 2'b11; end
            2'd2: begin e.as1 = 1'b1; e.as2 = 2'b10; e.aluop = 2'b00; end
            default: begin e.jump = 1'b1; e.cond = f[0]; e.jv = f[2:1]; e.pcw = ~f[0] | z; end
        endcase
        check_ctl("exec", ctl_a, e);
        @(negedge clk);
        if (opc == 2'd3) begin
            exp_count++;
            return;
        end
        if (opc == 2'd2) begin
            for (int w = 0; w <= mwait; w++) begin
                junk();
                mem_ready = (w == mwait);
                #1 e = '0; e.mw = f[0]; e.mr = ~f[0];
                check_ctl("mem", ctl_a, e);
                @(negedge clk);
            end
            if (f[0]) begin
                exp_count++;
                return;
            end
        end
        junk(); mem_ready = 1'($urandom);
        #1 e = '0; e.rw = 1'b1; e.rdst = (opc == 2'd0); e.m2r = (opc == 2'd2);
        check_ctl("wb", ctl_a, e);
        @(negedge clk);
        exp_count++;
    endtask

    // Holds inputs steady and measures latency and which controls appear until the next FETCH.
    task automatic run_vec(input vec_t v, input int idx);
        int cyc = 0, rw = 0, mw = 0, m2r = 0, pcw = 0;
        bit done = 0;
        logic [15:0] c0 = a_cnt;
        opcode = v.opc; funct = v.f; zero = v.z;
        while (!done && cyc < 40) begin
            mem_ready = !(cyc >= 3 && cyc < 3 + v.mwait);
            #1;
            rw  = rw  | int'(a_rw);
            mw  = mw  | int'(a_mw);
            m2r = m2r | int'(a_m2r);
            pcw = pcw + int'(a_pcw);
            @(negedge clk);
            cyc++;
            done = a_mr && (a_as2 == 2'b01);
        end
        check_int($sformatf("vec%0d_latency", idx), cyc, v.cyc);
        check_int($sformatf("vec%0d_regwrite", idx), rw, v.rw);
        check_int($sformatf("vec%0d_menwrite", idx), mw, v.mw);
        check_int($sformatf("vec%0d_mentoreg", idx), m2r, v.m2r);
        check_int($sformatf("vec%0d_pcwrites", idx), pcw, v.pcw);
        check_int($sformatf("vec%0d_retire", idx), int'(16'(a_cnt - c0)), v.ret);
        exp_count += v.ret;
    endtask

    initial begin
        vec_t tbl[9];
        ctl_t e;
        logic [1:0] ro;
        logic [2:0] rf;

        tbl[0] = '{2'b00, 3'b010, 1'b0, 0, 4, 1, 0, 0, 1, 1};
        tbl[1] = '{2'b01, 3'b000, 1'b0, 0, 4, 1, 0, 0, 1, 1};
        tbl[2] = '{2'b10, 3'b000, 1'b0, 0, 5, 1, 0, 1, 1, 1};
        tbl[3] = '{2'b10, 3'b000, 1'b0, 3, 8, 1, 0, 1, 1, 1};
        tbl[4] = '{2'b10, 3'b001, 1'b0, 0, 4, 0, 1, 0, 1, 1};
        tbl[5] = '{2'b11, 3'b001, 1'b0, 0, 3, 0, 0, 0, 1, 1};
        tbl[6] = '{2'b11, 3'b001, 1'b1, 0, 3, 0, 0, 0, 2, 1};
        tbl[7] = '{2'b11, 3'b110, 1'b0, 0, 3, 0, 0, 0, 2, 1};
        tbl[8] = '{2'b10, 3'b011, 1'b1, 2, 6, 0, 1, 0, 1, 1};

        rst_n = 1'b0; opc_hi = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_ctl("reset_a", ctl_a, '0);
        check_ctl("reset_b", ctl_b, '0);
        check_count();

        rst_n = 1'b1;
        #1 check_ctl("idle", ctl_a, '0);
        @(negedge clk);

        run_instr(2'b00, 3'b010, 1'b0, 0, 0);
        check_count();

        for (int i = 0; i < 9; i++) run_vec(tbl[i], i);

        for (int n = 0; n < 60; n++) begin
            ro = 2'($urandom);
            rf = 3'($urandom);
            if (ro == 2'b11 && rf == 3'b111) rf = 3'b101;
            run_instr(ro, rf, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        check_count();

        mem_ready = 1'b1; junk();
        #1 check_ctl("halt_fetch", ctl_a, fetch_exp(1'b1));
        @(negedge clk);
        opcode = 2'b11; funct = 3'b111;
        #1 e = '0; e.ro1 = 1'b1; e.ro2 = 1'b1;
        check_ctl("halt_decode", ctl_a, e);
        @(negedge clk);
        e = '0; e.halted = 1'b1;
        for (int i = 0; i < 20; i++) begin
            junk(); mem_ready = 1'($urandom);
            #1 check_ctl("halted", ctl_a, e);
            @(negedge clk);
        end
        check_count();

        #2 rst_n = 1'b0;
        #1;
        check_ctl("async_reset_a", ctl_a, '0);
        check_ctl("async_reset_b", ctl_b, '0);
        exp_count = 0;
        check_count();

        @(negedge clk);
        rst_n = 1'b1; opc_hi = 1'b0; mem_ready = 1'b1;
        #1 check_ctl("b_idle", ctl_b, '0);
        @(negedge clk);
        #1 check_ctl("b_fetch", ctl_b, fetch_exp(1'b1));
        @(negedge clk);
        opcode = 2'b01; opc_hi = 1'b1; funct = 3'b000;
        #1 e = '0; e.ro1 = 1'b1; e.ro2 = 1'b1; e.ill = 1'b1;
        check_ctl("b_illegal", ctl_b, e);
        @(negedge clk);
        opc_hi = 1'b0; junk(); mem_ready = 1'b0;
        #1 check_ctl("b_after_illegal", ctl_b, fetch_exp(1'b0));
        check_int("b_illegal_no_retire", int'(b_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
